// File: rtl/mem_arbiter.sv
// mem_arbiter -- shares one unified instruction/data memory between the
// multicycle CPU datapath (cpu_*) and an external requester (ext_*: program
// loader / debug). One access in flight at a time.
//
// Flow: IDLE -> ISSUE -> WAIT x MEM_LATENCY -> RESP -> IDLE for reads, and
// IDLE -> ISSUE -> RESP -> IDLE for writes. The winner's request is latched
// in IDLE, so the requester may drop or change its request once granted.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   cpu_req/we/addr/wdata   CPU request (level)
//   cpu_ready           one-cycle completion pulse to the CPU
//   cpu_rdata           CPU read data, held until the next CPU read completes
//   ext_*               same as cpu_*, for the external port
//   mem_en/we/addr/wdata    memory strobe and request; mem_en is high for one
//                           cycle per access, mem_we only together with it
//   mem_rdata           memory read data, valid MEM_LATENCY cycles after mem_en
//   owner               00 idle, 01 CPU, 10 EXT
//
// Build option
//   MEM_ARB_ROUND_ROBIN_EN  defined: simultaneous requests alternate, with the
//                           grant going to the port that did not win last
//                           (first tie after reset goes to the CPU).
//                           undefined: fixed priority, the CPU wins every tie.
module mem_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ready,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  ext_req,
  input  logic                  ext_we,
  input  logic [ADDR_WIDTH-1:0] ext_addr,
  input  logic [DATA_WIDTH-1:0] ext_wdata,
  output logic                  ext_ready,
  output logic [DATA_WIDTH-1:0] ext_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [1:0]            owner
);

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_CPU  = 2'b01;
  localparam logic [1:0] OWN_EXT  = 2'b10;
  localparam int         CW       = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  state_t          state, state_nxt;
  req_t            cpu_rq, ext_rq, lat_q;
  logic            any_req, grant_cpu, wait_last;
  logic [CW-1:0]   wait_cnt;

  assign cpu_rq    = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
  assign ext_rq    = '{we: ext_we, addr: ext_addr, wdata: ext_wdata};
  assign any_req   = cpu_req | ext_req;
  assign wait_last = (wait_cnt == CW'(MEM_LATENCY - 1));

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Only the alternation policy needs grant history.
  logic [1:0] last_owner;

  always_ff @(posedge clk) begin
    if (rst)                         last_owner <= OWN_EXT;
    else if (state == S_IDLE && any_req) last_owner <= grant_cpu ? OWN_CPU : OWN_EXT;
  end

  always_comb begin
    grant_cpu = cpu_req;
    if (cpu_req && ext_req) grant_cpu = (last_owner == OWN_EXT);
  end
`else
  // CPU wins whenever it asks; EXT only gets the memory when the CPU is quiet.
  always_comb grant_cpu = cpu_req;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (any_req) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = lat_q.we ? S_RESP : S_WAIT;
      S_WAIT:  if (wait_last) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    mem_en    = (state == S_ISSUE);
    mem_we    = (state == S_ISSUE) & lat_q.we;
    mem_addr  = lat_q.addr;   // held between accesses
    mem_wdata = lat_q.wdata;
    cpu_ready = (state == S_RESP) && (owner == OWN_CPU);
    ext_ready = (state == S_RESP) && (owner == OWN_EXT);
  end

  // Latched request, owner, latency counter and read-data holding registers
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_q     <= '0;
      owner     <= OWN_NONE;
      wait_cnt  <= '0;
      cpu_rdata <= '0;
      ext_rdata <= '0;
    end else begin
      case (state)
        S_IDLE: if (any_req) begin
          lat_q <= grant_cpu ? cpu_rq : ext_rq;
          owner <= grant_cpu ? OWN_CPU : OWN_EXT;
        end
        S_ISSUE: wait_cnt <= '0;
        S_WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          // mem_rdata is valid in the last WAIT cycle only
          if (wait_last) begin
            if (owner == OWN_CPU) cpu_rdata <= mem_rdata;
            else                  ext_rdata <= mem_rdata;
          end
        end
        S_RESP: owner <= OWN_NONE;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: MEM_LATENCY=2, behavioural memory device plus a
// transaction-level reference model (scoreboard memory, expected rdata per
// port, grant policy from last grantee, latency from access type).
module tb_mem_arbiter;
  localparam int AW = 32, DW = 32, LAT = 2;
  localparam logic [1:0] O_CPU = 2'b01, O_EXT = 2'b10;

  logic clk = 1'b0, rst = 1'b1;
  logic cpu_req = 0, cpu_we = 0, ext_req = 0, ext_we = 0;
  logic [AW-1:0] cpu_addr = '0, ext_addr = '0, mem_addr;
  logic [DW-1:0] cpu_wdata = '0, ext_wdata = '0, cpu_rdata, ext_rdata, mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic cpu_ready, ext_ready, mem_en, mem_we;
  logic [1:0] owner;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_ready(ext_ready), .ext_rdata(ext_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner));

  int checks = 0, errors = 0;
  int cyc = 0;

  // ---------------- memory device ----------------
  logic [31:0] dev_mem [logic [31:0]];
  logic [31:0] rd_val = '0;
  int rd_due = -1;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  // Read data appears only in the cycle exactly LAT after the strobe; noise otherwise.
  always @(posedge clk) begin
    cyc++;
    #1 mem_rdata = (cyc == rd_due) ? rd_val : $urandom;
  end

  // ---------------- monitor ----------------
  int n_cpu_rdy = 0, n_ext_rdy = 0, n_men = 0, n_bad_we = 0, last_men_cyc = -1;
  logic last_men_we = 0;
  logic [31:0] last_men_addr = '0, last_men_wd = '0;
  logic [1:0] last_men_owner = '0;

  always @(negedge clk) begin
    if (cpu_ready) n_cpu_rdy++;
    if (ext_ready) n_ext_rdy++;
    if (mem_we && !mem_en) n_bad_we++;
    if (mem_en) begin
      n_men++; last_men_cyc = cyc; last_men_we = mem_we;
      last_men_addr = mem_addr; last_men_wd = mem_wdata; last_men_owner = owner;
      if (mem_we) dev_mem[mem_addr] = mem_wdata;
      else begin
        rd_val = dev_mem.exists(mem_addr) ? dev_mem[mem_addr] : dflt(mem_addr);
        rd_due = cyc + LAT;
      end
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] sb_mem [logic [31:0]];
  logic [1:0]  m_last = O_EXT;
  logic [31:0] exp_cpu_rd = '0, exp_ext_rd = '0;

  function automatic int lat_of(input bit we);
    return we ? 2 : 2 + LAT;
  endfunction

  // Who wins when both ask, given the previous grantee.
  function automatic logic [1:0] tie_winner(input logic [1:0] prev);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    return (prev == O_EXT) ? O_CPU : O_EXT;
`else
    return O_CPU;
`endif
  endfunction

  function automatic void m_do(input logic [1:0] who, input bit we, input logic [31:0] a, d);
    logic [31:0] v;
    m_last = who;
    if (we) sb_mem[a] = d;
    else begin
      v = sb_mem.exists(a) ? sb_mem[a] : dflt(a);
      if (who == O_CPU) exp_cpu_rd = v; else exp_ext_rd = v;
    end
  endfunction

  function automatic void m_reset();
    m_last = O_EXT; exp_cpu_rd = '0; exp_ext_rd = '0;
  endfunction

  // ---------------- stimulus helpers ----------------
  int t0, r_c, r_e, c0_rdy, e0_rdy, men0;
  bit r_tmo;

  task automatic run_txn(input bit ce, input bit cw, input logic [31:0] ca, cd,
                         input bit ee, input bit ew, input logic [31:0] ea, ed,
                         input bit edrop);
    c0_rdy = n_cpu_rdy; e0_rdy = n_ext_rdy; men0 = n_men;
    @(posedge clk); #1;
    cpu_req = ce; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    ext_req = ee; ext_we = ew; ext_addr = ea; ext_wdata = ed;
    t0 = cyc; r_c = -1; r_e = -1; r_tmo = 1;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (edrop && cyc == t0 + 1) ext_req = 0;
      if (cpu_ready && r_c < 0) begin r_c = cyc; cpu_req = 0; end
      if (ext_ready && r_e < 0) begin r_e = cyc; ext_req = 0; end
      if ((!ce || r_c >= 0) && (!ee || r_e >= 0)) begin r_tmo = 0; break; end
    end
    cpu_req = 0; ext_req = 0;
    repeat (3) @(posedge clk);
  endtask

  task automatic apply_reset();
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    m_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if ({mem_en, mem_we, cpu_ready, ext_ready} !== 4'b0) begin errors++;
      $display("FAIL reset_strobes: got %b expected 0000", {mem_en, mem_we, cpu_ready, ext_ready}); end
    checks++; if (owner !== 2'b00) begin errors++;
      $display("FAIL reset_owner: got %b expected 00", owner); end
    checks++; if ({mem_addr, mem_wdata, cpu_rdata, ext_rdata} !== 128'b0) begin errors++;
      $display("FAIL reset_data: got %h %h %h %h expected zeros", mem_addr, mem_wdata, cpu_rdata, ext_rdata); end
    @(posedge clk); #1 rst = 0;
    m_reset();
  endtask

  task automatic test_cpu_read();
    dev_mem[32'h10] = 32'hDEADBEEF; sb_mem[32'h10] = 32'hDEADBEEF;
    m_do(O_CPU, 0, 32'h10, 0);
    run_txn(1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
    checks++; if (r_tmo || r_c != t0 + 2 + LAT) begin errors++;
      $display("FAIL cpu_read_latency: got cycle %0d (timeout %0d) expected %0d", r_c, r_tmo, t0 + 2 + LAT); end
    checks++; if (cpu_rdata !== 32'hDEADBEEF) begin errors++;
      $display("FAIL cpu_read_data: got %h expected deadbeef", cpu_rdata); end
    checks++; if (n_men - men0 != 1 || last_men_cyc != t0 + 1 || last_men_we !== 1'b0 || last_men_addr !== 32'h10) begin errors++;
      $display("FAIL cpu_read_strobe: got n=%0d cyc=%0d we=%b addr=%h expected n=1 cyc=%0d we=0 addr=10",
               n_men - men0, last_men_cyc, last_men_we, last_men_addr, t0 + 1); end
    checks++; if (last_men_owner !== O_CPU) begin errors++;
      $display("FAIL cpu_read_owner: got %b expected 01", last_men_owner); end
    checks++; if (n_ext_rdy != e0_rdy || n_cpu_rdy - c0_rdy != 1) begin errors++;
      $display("FAIL cpu_read_pulses: got cpu=%0d ext=%0d expected cpu=1 ext=0", n_cpu_rdy - c0_rdy, n_ext_rdy - e0_rdy); end
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++; if (cpu_rdata !== 32'hDEADBEEF || owner !== 2'b00) begin errors++;
      $display("FAIL cpu_read_hold: got rdata=%h owner=%b expected deadbeef 00", cpu_rdata, owner); end
  endtask

  task automatic test_ext_write();
    m_do(O_EXT, 1, 32'h20, 32'h1234);
    run_txn(0, 0, 0, 0, 1, 1, 32'h20, 32'h0000_1234, 0);
    checks++; if (r_tmo || r_e != t0 + 2) begin errors++;
      $display("FAIL ext_write_latency: got cycle %0d expected %0d", r_e, t0 + 2); end
    checks++; if (last_men_cyc != t0 + 1 || last_men_we !== 1'b1 || last_men_addr !== 32'h20 || last_men_wd !== 32'h1234) begin errors++;
      $display("FAIL ext_write_strobe: got cyc=%0d we=%b addr=%h wd=%h expected cyc=%0d we=1 addr=20 wd=1234",
               last_men_cyc, last_men_we, last_men_addr, last_men_wd, t0 + 1); end
    checks++; if (cpu_rdata !== exp_cpu_rd || ext_rdata !== exp_ext_rd) begin errors++;
      $display("FAIL ext_write_rdata: got %h %h expected %h %h", cpu_rdata, ext_rdata, exp_cpu_rd, exp_ext_rd); end
    m_do(O_EXT, 0, 32'h20, 0);
    run_txn(0, 0, 0, 0, 1, 0, 32'h20, 0, 0);
    checks++; if (r_tmo || ext_rdata !== 32'h1234 || r_e != t0 + 2 + LAT) begin errors++;
      $display("FAIL ext_readback: got %h at %0d expected 00001234 at %0d", ext_rdata, r_e, t0 + 2 + LAT); end
  endtask

  task automatic test_tie();
    logic [1:0] got [4];
    int gc [4];
    int n;
    logic [1:0] prev, w;
    apply_reset();
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    ext_req = 1; ext_we = 0; ext_addr = 32'h20;
    t0 = cyc; n = 0;
    for (int k = 0; k < 100 && n < 4; k++) begin
      @(negedge clk);
      if (cpu_ready && n < 4) begin got[n] = O_CPU; gc[n] = cyc; n++; end
      if (ext_ready && n < 4) begin got[n] = O_EXT; gc[n] = cyc; n++; end
    end
    cpu_req = 0; ext_req = 0;
    checks++; if (n != 4) begin errors++;
      $display("FAIL tie_count: got %0d grants expected 4", n); end
    prev = m_last;
    for (int i = 0; i < n; i++) begin
      w = tie_winner(prev); prev = w;
      checks++; if (got[i] !== w || gc[i] != t0 + lat_of(0) + i * (lat_of(0) + 1)) begin errors++;
        $display("FAIL tie_grant%0d: got %b at %0d expected %b at %0d", i, got[i], gc[i], w, t0 + lat_of(0) + i * (lat_of(0) + 1)); end
      m_do(w, 0, (w == O_CPU) ? 32'h10 : 32'h20, 0);
    end
    repeat (3) @(posedge clk);
    checks++; if (cpu_rdata !== exp_cpu_rd || ext_rdata !== exp_ext_rd) begin errors++;
      $display("FAIL tie_rdata: got %h %h expected %h %h", cpu_rdata, ext_rdata, exp_cpu_rd, exp_ext_rd); end
  endtask

  task automatic test_back_to_back();
    int p [3];
    int n;
    men0 = n_men;
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h30; cpu_wdata = 32'hCAFE_0001;
    t0 = cyc; n = 0;
    for (int k = 0; k < 40 && n < 3; k++) begin
      @(negedge clk);
      if (cpu_ready) begin p[n] = cyc; n++; if (n == 3) cpu_req = 0; end
    end
    cpu_req = 0;
    repeat (3) @(posedge clk);
    for (int i = 0; i < 3; i++) m_do(O_CPU, 1, 32'h30, 32'hCAFE_0001);
    checks++; if (n != 3 || p[0] != t0 + 2 || p[1] - p[0] != 3 || p[2] - p[1] != 3) begin errors++;
      $display("FAIL b2b_spacing: got n=%0d at %0d,%0d,%0d expected 3 at %0d,+3,+3", n, p[0], p[1], p[2], t0 + 2); end
    checks++; if (n_men - men0 != 3) begin errors++;
      $display("FAIL b2b_strobes: got %0d expected 3", n_men - men0); end
    m_do(O_CPU, 0, 32'h30, 0);
    run_txn(1, 0, 32'h30, 0, 0, 0, 0, 0, 0);
    checks++; if (r_tmo || cpu_rdata !== exp_cpu_rd) begin errors++;
      $display("FAIL b2b_readback: got %h expected %h", cpu_rdata, exp_cpu_rd); end
  endtask

  task automatic test_reset_mid();
    int c0;
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    t0 = cyc;
    @(posedge clk); #1 cpu_req = 0;      // ISSUE
    @(posedge clk); #1 rst = 1;          // first WAIT cycle
    @(posedge clk); #1 rst = 0;
    c0 = n_cpu_rdy;
    m_reset();
    @(negedge clk);
    checks++; if ({mem_en, mem_we, cpu_ready, ext_ready, owner} !== 6'b0) begin errors++;
      $display("FAIL midreset_ctrl: got %b expected 000000", {mem_en, mem_we, cpu_ready, ext_ready, owner}); end
    checks++; if ({mem_addr, mem_wdata, cpu_rdata, ext_rdata} !== 128'b0) begin errors++;
      $display("FAIL midreset_data: got %h %h %h %h expected zeros", mem_addr, mem_wdata, cpu_rdata, ext_rdata); end
    repeat (6) @(posedge clk);
    checks++; if (n_cpu_rdy != c0) begin errors++;
      $display("FAIL midreset_noready: got %0d pulses expected 0", n_cpu_rdy - c0); end
    m_do(O_CPU, 0, 32'h10, 0);
    run_txn(1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
    checks++; if (r_tmo || r_c != t0 + 2 + LAT || cpu_rdata !== exp_cpu_rd) begin errors++;
      $display("FAIL midreset_recover: got %h at %0d expected %h at %0d", cpu_rdata, r_c, exp_cpu_rd, t0 + 2 + LAT); end
  endtask

  task automatic test_ext_drop();
    m_do(O_EXT, 0, 32'h20, 0);
    run_txn(0, 0, 0, 0, 1, 0, 32'h20, 0, 1);
    checks++; if (r_tmo || r_e != t0 + 2 + LAT || n_ext_rdy - e0_rdy != 1) begin errors++;
      $display("FAIL ext_drop: got cycle %0d pulses %0d expected cycle %0d pulses 1", r_e, n_ext_rdy - e0_rdy, t0 + 2 + LAT); end
    checks++; if (ext_rdata !== exp_ext_rd) begin errors++;
      $display("FAIL ext_drop_data: got %h expected %h", ext_rdata, exp_ext_rd); end
  endtask

  task automatic test_random();
    bit ce, ee, cw, ew;
    logic [31:0] ca, cd, ea, ed;
    logic [1:0] w;
    int oc, oe, pat;
    for (int i = 0; i < 24; i++) begin
      pat = $urandom_range(0, 2);
      ce = (pat != 1); ee = (pat != 0);
      cw = $urandom_range(0, 1); ew = $urandom_range(0, 1);
      ca = 32'h100 + 4 * $urandom_range(0, 3); ea = 32'h100 + 4 * $urandom_range(0, 3);
      cd = $urandom; ed = $urandom;
      oc = 0; oe = 0;
      if (ce && ee) begin
        w = tie_winner(m_last);
        if (w == O_CPU) begin
          oc = lat_of(cw); oe = oc + 1 + lat_of(ew);
          m_do(O_CPU, cw, ca, cd); m_do(O_EXT, ew, ea, ed);
        end else begin
          oe = lat_of(ew); oc = oe + 1 + lat_of(cw);
          m_do(O_EXT, ew, ea, ed); m_do(O_CPU, cw, ca, cd);
        end
      end else if (ce) begin
        oc = lat_of(cw); m_do(O_CPU, cw, ca, cd);
      end else begin
        oe = lat_of(ew); m_do(O_EXT, ew, ea, ed);
      end
      run_txn(ce, cw, ca, cd, ee, ew, ea, ed, 0);
      checks++; if (r_tmo) begin errors++;
        $display("FAIL rand%0d_timeout: got no completion expected cpu=%0d ext=%0d", i, ce, ee); end
      if (ce) begin
        checks++; if (r_c != t0 + oc) begin errors++;
          $display("FAIL rand%0d_cpu_cycle: got %0d expected %0d", i, r_c, t0 + oc); end
      end
      if (ee) begin
        checks++; if (r_e != t0 + oe) begin errors++;
          $display("FAIL rand%0d_ext_cycle: got %0d expected %0d", i, r_e, t0 + oe); end
      end
      checks++; if (n_cpu_rdy - c0_rdy != int'(ce) || n_ext_rdy - e0_rdy != int'(ee)) begin errors++;
        $display("FAIL rand%0d_pulses: got %0d %0d expected %0d %0d", i, n_cpu_rdy - c0_rdy, n_ext_rdy - e0_rdy, ce, ee); end
      checks++; if (cpu_rdata !== exp_cpu_rd || ext_rdata !== exp_ext_rd) begin errors++;
        $display("FAIL rand%0d_rdata: got %h %h expected %h %h", i, cpu_rdata, ext_rdata, exp_cpu_rd, exp_ext_rd); end
    end
    checks++; if (n_bad_we != 0) begin errors++;
      $display("FAIL we_without_en: got %0d cycles expected 0", n_bad_we); end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_ext_write();
    test_tie();
    test_back_to_back();
    test_reset_mid();
    test_ext_drop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish before 400000");
    $fatal(1);
  end
endmodule
